// File: rtl/floating_point_normalizer_pkg.sv
// Shared types and helpers for the binary32 normalizer that feeds the rounder.
// Covers the packed float format, rounding bits and the stage-1 pipeline record.
package floating_point_normalizer_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } float32_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } round_bits_t;

  typedef struct packed {
    logic        sign;
    logic        c;
    logic [5:0]  lz;
    logic [10:0] e_adj;
    logic [47:0] significand;
    logic        valid;
  } norm_stage1_t;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Leading zeros of one byte; 8 when the byte is empty.
  function automatic logic [3:0] lzc8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) n = 4'(7 - i);
      else      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/floating_point_normalizer_if.sv
// Operand/result bundle between the FP datapath and the normalizer.
// The master drives operands and pipeline control, the slave returns results.
interface floating_point_normalizer_if;
  import floating_point_normalizer_pkg::*;

  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  logic        sign_i;
  logic [9:0]  exponent_i;
  logic [47:0] significand_i;
  logic        valid_o;
  float32_t    result_o;
  round_bits_t round_bits_o;
  logic        overflow_o;
  logic        underflow_o;

  modport master (
    output stall_i, flush_i, valid_i, sign_i, exponent_i, significand_i,
    input  valid_o, result_o, round_bits_o, overflow_o, underflow_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, sign_i, exponent_i, significand_i,
    output valid_o, result_o, round_bits_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/fp_leading_zero_counter.sv
// 48-bit leading-zero counter built as a two-level tree: byte counts, then a
// priority pick of the most significant non-empty byte. Purely combinational.
module fp_leading_zero_counter
  import floating_point_normalizer_pkg::*;
(
  input  logic [47:0] data,
  output logic [5:0]  count
);

  logic [3:0] byte_lz_s [6];
  logic [5:0] byte_nz_s;

  // First tree level: per-byte leading-zero counts and occupancy
  always_comb begin
    for (int g = 0; g < 6; g++) begin
      byte_lz_s[g] = lzc8(data[g*8 +: 8]);
      byte_nz_s[g] = |data[g*8 +: 8];
    end
  end

  // Second tree level: higher bytes override lower ones
  always_comb begin
    count = 6'd48;
    for (int g = 0; g < 6; g++) begin
      if (byte_nz_s[g]) count = 6'((5 - g) * 8) + {2'b00, byte_lz_s[g]};
      else              count = count;
    end
  end

endmodule

// File: rtl/floating_point_normalizer.sv
// Two-stage normalizer: stage 1 registers operands with LZC and exponent
// adjust, stage 2 shifts, extracts fraction/GRS and raises overflow/underflow.
module floating_point_normalizer
  import floating_point_normalizer_pkg::*;
(
  input logic                        clk_i,
  input logic                        rst_i,
  floating_point_normalizer_if.slave bus
);

  logic [5:0]         lz_s;
  logic signed [10:0] exp_ext_s;
  logic signed [10:0] e_adj_s;
  norm_stage1_t       s1_r;

  logic signed [10:0] e_adj2_s;
  logic signed [10:0] exp_in_s;
  logic signed [10:0] exp_field_s;
  logic [5:0]         lshamt_s;
  logic [5:0]         rshamt_s;
  logic [47:0]        shifted_s;
  logic               lost_s;
  logic [22:0]        frac_s;
  logic               guard_s;
  logic               rnd_s;
  logic               sticky_s;
  float32_t           result_s;
  round_bits_t        rb_s;
  logic               ovf_s;
  logic               udf_s;

  logic               valid_r;
  float32_t           result_r;
  round_bits_t        rb_r;
  logic               ovf_r;
  logic               udf_r;

  // Trailing 1 caps the count at 47 when bits [46:0] are all zero.
  fp_leading_zero_counter u_lzc (
    .data  ({bus.significand_i[46:0], 1'b1}),
    .count (lz_s)
  );

  // Stage-1 exponent adjustment for carry-out or leading zeros
  always_comb begin
    exp_ext_s = {bus.exponent_i[9], bus.exponent_i};
    if (bus.significand_i[47]) e_adj_s = exp_ext_s + 11'sd1;
    else                       e_adj_s = exp_ext_s - $signed({5'd0, lz_s});
  end

  // Stage-2 shifter; the original exponent is recovered as e_adj + lz
  always_comb begin
    e_adj2_s    = s1_r.e_adj;
    exp_in_s    = e_adj2_s + $signed({5'd0, s1_r.lz});
    lshamt_s    = exp_in_s[5:0] - 6'd1;
    shifted_s   = 48'd0;
    lost_s      = 1'b0;
    exp_field_s = 11'sd0;
    if (exp_in_s <= -11'sd47) rshamt_s = 6'd48;
    else                      rshamt_s = 6'd1 - exp_in_s[5:0];
    if (s1_r.c) begin
      shifted_s   = s1_r.significand >> 1;
      lost_s      = s1_r.significand[0];
      exp_field_s = e_adj2_s;
    end else if (e_adj2_s >= 11'sd1) begin
      shifted_s   = s1_r.significand << s1_r.lz;
      exp_field_s = e_adj2_s;
    end else if (exp_in_s >= 11'sd1) begin
      shifted_s   = s1_r.significand << lshamt_s;
    end else begin
      shifted_s   = s1_r.significand >> rshamt_s;
      lost_s      = |(s1_r.significand & ~({48{1'b1}} << rshamt_s));
    end
    frac_s   = shifted_s[45:23];
    guard_s  = shifted_s[22];
    rnd_s    = shifted_s[21];
    sticky_s = (|shifted_s[20:0]) | lost_s;
  end

  // Result packing with zero, overflow and underflow overrides
  always_comb begin
    result_s = '{sign: s1_r.sign, exponent: exp_field_s[7:0], fraction: frac_s};
    rb_s     = '{guard: guard_s, round: rnd_s, sticky: sticky_s};
    ovf_s    = 1'b0;
    udf_s    = 1'b0;
    if (s1_r.significand == 48'd0) begin
      result_s = '{sign: s1_r.sign, exponent: 8'd0, fraction: 23'd0};
      rb_s     = 3'b000;
    end else if (exp_field_s >= $signed(11'(EXP_MAX))) begin
      result_s = '{sign: s1_r.sign, exponent: 8'hFF, fraction: 23'd0};
      rb_s     = 3'b000;
      ovf_s    = 1'b1;
    end else if (exp_field_s == 11'sd0 && frac_s == 23'd0 && !guard_s) begin
      result_s = '{sign: s1_r.sign, exponent: 8'd0, fraction: 23'd0};
      udf_s    = 1'b1;
    end else begin
      result_s = result_s;
    end
  end

  // Pipeline registers: flush beats stall, stall freezes both stages
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_r     <= '0;
      valid_r  <= 1'b0;
      result_r <= '0;
      rb_r     <= '0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else if (bus.flush_i) begin
      s1_r.valid <= 1'b0;
      valid_r    <= 1'b0;
    end else if (!bus.stall_i) begin
      s1_r.valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1_r.sign        <= bus.sign_i;
        s1_r.c           <= bus.significand_i[47];
        s1_r.lz          <= lz_s;
        s1_r.e_adj       <= e_adj_s;
        s1_r.significand <= bus.significand_i;
      end
      valid_r <= s1_r.valid;
      if (s1_r.valid) begin
        result_r <= result_s;
        rb_r     <= rb_s;
        ovf_r    <= ovf_s;
        udf_r    <= udf_s;
      end
    end
  end

  assign bus.valid_o      = valid_r;
  assign bus.result_o     = result_r;
  assign bus.round_bits_o = rb_r;
  assign bus.overflow_o   = ovf_r;
  assign bus.underflow_o  = udf_r;

endmodule

// File: doc/floating_point_normalizer.md
# floating_point_normalizer

Two-stage pipelined normalizer that sits directly upstream of the floating point rounder. It takes the raw sign, wide exponent and unnormalized 48-bit significand produced by the FP adder, multiplier and divider. It outputs a packed single-precision value with the hidden bit removed, the guard/round/sticky bits, and overflow/underflow flags, which the rounder consumes. It handles carry-out renormalization, leading-zero left shifts, subnormal right shifts, and overflow saturation to infinity.

## Interface
Parameters: none (format fixed to binary32).
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset asynchronous and active-high
- stall_i  in  1  hold both pipeline stages and outputs
- flush_i  in  1  invalidate both stages
- valid_i  in  1  input operands valid
- sign_i  in  1  result sign
- exponent_i  in  10  signed biased exponent (may be <1 or >254)
- significand_i  in  48  fixed point, binary point between bit 46 and bit 45; bit 47 is carry
- valid_o  out  1  outputs valid
- result_o  out  32 (float32_t)  normalized value, hidden bit dropped
- round_bits_o  out  3 (round_bits_t)  guard, round, sticky
- overflow_o  out  1  result saturated to infinity
- underflow_o  out  1  nonzero input fully shifted out to zero

## Operation
- Stage 1 registers the inputs. It also computes:
  - c = significand_i[47]
  - lz = leading zeros of significand_i[46:0] (0..47)
  - e_adj = exponent_i + c − (c ? 0 : lz), 11-bit signed
- Stage 2 shifts the registered significand and builds the outputs. Exactly one of the following applies:
  - c=1: right shift 1, exponent field = e_adj. The bit shifted out feeds sticky.
  - c=0, e_adj ≥ 1: left shift lz, exponent field = e_adj.
  - c=0, e_adj < 1, exponent_i ≥ 1: left shift exponent_i − 1, exponent field 0 (subnormal).
  - c=0, exponent_i < 1: right shift min(1 − exponent_i, 48), exponent field 0. All bits shifted out OR into sticky.
- Field extraction after the shift:
  - fraction = shifted[45:23]
  - guard = [22], round = [21]
  - sticky = |[20:0] OR any right-shifted-out bit
- Zero input (significand_i == 0): result = {sign, 0, 0}, round bits 0, both flags 0. The lz = 47 path must not produce a negative exponent.
- Overflow: exponent field ≥ 255 after adjustment. Then result = {sign, 8'hFF, 0}, round bits 0, overflow_o = 1.
- Underflow: input nonzero, exponent field 0, fraction 0 and guard 0. Then result = {sign, 0, 0}, underflow_o = 1. Sticky and round are still reported.
- Flag behaviour:
  - Flags are mutually exclusive.
  - Flags and round bits are meaningful only when valid_o = 1.
  - The outputs do not handle NaN or infinity inputs; special operands bypass this block.

## Timing
- Latency: 2 cycles from valid_i to valid_o. Throughput: 1 per cycle.
- stall_i = 1 freezes both stage registers and all outputs. valid_i is ignored during a stall.
- flush_i = 1 clears both stage valids on the next edge; data registers are don't-care.
- Flush has priority over stall. Flush with valid_i = 1 in the same cycle drops that input.
- On reset, all outputs are 0: valid_o = 0, result_o = 0, round_bits_o = 0, overflow_o = 0, underflow_o = 0.
- Reset in the middle of operation discards both in-flight entries.
- Data registers load only when their stage is not stalled. valid_o = 0 outputs keep their last value.

## Structure
- float32_t and round_bits_t come from the floating point unit package.
- Add to the same package:
  - norm_stage1_t: sign, c, lz[5:0], e_adj[10:0], significand[47:0], valid
  - constants BIAS = 127, EXP_MAX = 255
- One sub-module: fp_leading_zero_counter. It is a 48-bit tree LZC, purely combinational, instantiated in stage 1.
- The top module contains the pipeline registers, the shifter and the flag logic.

## Test plan
- 1.0: significand = 1<<46, exp 127 → result 0x3F800000, rb 000, flags 0, valid_o 2 cycles later.
- Carry: significand = 3<<46, exp 127 → 0x40400000. Also significand = 1<<40, exp 127 → 0x3C800000.
- Subnormal: significand = 1<<46, exp 0 → 0x00400000, no flags. exp −60 with the same significand → 0x00000000, underflow_o = 1, sticky = 1.
- Overflow: significand = 1<<47, exp 254 → 0x7F800000, overflow_o = 1. Sign 1 → 0xFF800000.
- Round bits: significand = (1<<46)|(1<<22)|1, exp 127 → 0x3F800000, guard 1, round 0, sticky 1. Zero significand → signed zero, no flags.
- Pipeline control:
  - Back-to-back inputs with stall_i = 1 for 3 cycles → outputs held and no input lost.
  - flush_i = 1 with two entries in flight → valid_o = 0 for the next 2 cycles.
  - rst_i pulsed mid-stream → all outputs 0 immediately.
